// File: rtl/oled_pkg.sv
// Shared types and default geometry for the OLED frame writer and the oled_controller it feeds.
package oled_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_e;
  typedef enum logic [1:0] {PAT_OFF = 2'd0, PAT_ON = 2'd1, PAT_CHECK = 2'd2, PAT_RAMP = 2'd3} pat_e;
  localparam int OLED_COLS  = 128;
  localparam int OLED_PAGES = 4;
endpackage

// File: rtl/oled_frame_writer_if.sv
// Byte-push link into the controller input buffer: producer drives data/valid, controller drives full.
interface oled_frame_writer_if;
  logic [7:0] data_out;
  logic       write_enable;
  logic       buffer_full;
  modport master (output data_out, output write_enable, input buffer_full);
  modport slave  (input data_out, input write_enable, output buffer_full);
endinterface

// File: rtl/oled_pattern_gen.sv
// Combinational test-pattern source: (pattern, page, column, scroll offset) -> pixel byte.
module oled_pattern_gen
  import oled_pkg::*;
(
  input  pat_e       pat_i,
  input  logic       page_odd_i,
  input  logic [7:0] col_i,
  input  logic [7:0] offset_i,
  output logic [7:0] pix_o
);
  logic [7:0] c;

  always_comb begin
    c     = col_i + offset_i;
    pix_o = 8'h00;
    case (pat_i)
      PAT_OFF:   pix_o = 8'h00;
      PAT_ON:    pix_o = 8'hFF;
      // 8x8 checkerboard: 8-column bands toggled on alternate pages
      PAT_CHECK: pix_o = (c[3] ^ page_odd_i) ? 8'hFF : 8'h00;
      PAT_RAMP:  pix_o = c;
      default:   pix_o = 8'h00;
    endcase
  end
endmodule

// File: rtl/oled_frame_writer.sv
// Streams page-major frames of pattern bytes into the controller buffer, with an idle gap between frames.
module oled_frame_writer
  import oled_pkg::*;
#(
  parameter int COLS       = OLED_COLS,
  parameter int PAGES      = OLED_PAGES,
  parameter int GAP_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [1:0]                 pattern_sel,
  oled_frame_writer_if.master        wr,
  output logic                       busy,
  output logic                       frame_done
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e        state_q;
  logic [CW-1:0] col_q;
  logic [PW-1:0] page_q;
  logic [7:0]    offset_q;
  pat_e          pat_q;
  logic [GW-1:0] gap_q;
  logic          done_q;
  logic [7:0]    pix;

  oled_pattern_gen u_gen (
    .pat_i      (pat_q),
    .page_odd_i (page_q[0]),
    .col_i      (8'(col_q)),
    .offset_i   (offset_q),
    .pix_o      (pix)
  );

  // Outputs decode registered state only, so buffer_full never reaches them combinationally.
  assign wr.write_enable = (state_q == WRITE);
  assign wr.data_out     = (state_q == WRITE) ? pix : 8'h00;
  assign busy            = (state_q != IDLE);
  assign frame_done      = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      col_q    <= '0;
      page_q   <= '0;
      offset_q <= '0;
      pat_q    <= PAT_OFF;
      gap_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (enable) begin
          pat_q   <= pat_e'(pattern_sel);
          col_q   <= '0;
          page_q  <= '0;
          state_q <= WRITE;
        end
        WRITE: if (!wr.buffer_full) begin
          if (col_q == CW'(COLS - 1)) begin
            col_q <= '0;
            if (page_q == PW'(PAGES - 1)) begin
              page_q   <= '0;
              gap_q    <= '0;
              offset_q <= offset_q + 8'd1;
              done_q   <= 1'b1;
              state_q  <= GAP;
            end else begin
              page_q <= page_q + PW'(1);
            end
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
        GAP: begin
          gap_q <= gap_q + GW'(1);
          if (gap_q == GW'(GAP_CYCLES - 1)) begin
            if (enable) begin
              pat_q   <= pat_e'(pattern_sel);
              col_q   <= '0;
              page_q  <= '0;
              state_q <= WRITE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
